icache_responder: RTL and testbench



---
 rtl/icache_responder_pkg.sv | 35 +++
 rtl/icache_responder_tag_ram.sv | 43 ++++
 rtl/icache_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_icache_responder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_responder_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache responder.
package icache_responder_pkg;

  localparam int FAULT_W    = 4;
  localparam int MEM_SIZE_W = 2;

  typedef logic [FAULT_W-1:0] FaultTy;

  localparam FaultTy FAULT_NONE         = 4'd0;
  localparam FaultTy FAULT_LOAD_ACCESS  = 4'd5;
  localparam FaultTy FAULT_STORE_ACCESS = 4'd7;

  localparam int IC_INDEX_WIDTH = 6;
  localparam int IC_LINE_WORDS  = 4;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOOKUP      = 3'd1,
    REFILL_REQ  = 3'd2,
    REFILL_WAIT = 3'd3,
    RESPOND     = 3'd4
  } IcacheState;

  function automatic int offset_width(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int tag_width(input int index_width, input int line_words);
    return 32 - 2 - offset_width(line_words) - index_width;
  endfunction

  localparam int IC_OFFSET_WIDTH = offset_width(IC_LINE_WORDS);
  localparam int IC_TAG_WIDTH    = tag_width(IC_INDEX_WIDTH, IC_LINE_WORDS);

endpackage

// File: rtl/icache_responder_tag_ram.sv
// Tag and data storage for the instruction cache: word-granular refill writes,
// whole-tag writes and a combinational lookup port.
module icache_tag_ram
  import icache_responder_pkg::*;
#(
  parameter int INDEX_WIDTH  = IC_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = IC_OFFSET_WIDTH,
  parameter int TAG_WIDTH    = IC_TAG_WIDTH
) (
  input  logic                    clk,
  input  logic                    word_we,
  input  logic [INDEX_WIDTH-1:0]  word_index,
  input  logic [OFFSET_WIDTH-1:0] word_offset,
  input  logic [31:0]             word_data,
  input  logic                    tag_we,
  input  logic [INDEX_WIDTH-1:0]  tag_index,
  input  logic [TAG_WIDTH-1:0]    tag_data,
  input  logic [INDEX_WIDTH-1:0]  rd_index,
  input  logic [OFFSET_WIDTH-1:0] rd_offset,
  output logic [TAG_WIDTH-1:0]    rd_tag,
  output logic [31:0]             rd_word
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << (INDEX_WIDTH + OFFSET_WIDTH);

  logic [31:0]          data_r [0:WORDS-1];
  logic [TAG_WIDTH-1:0] tag_r  [0:LINES-1];

  // Storage writes; contents carry no reset since valid bits gate every use
  always_ff @(posedge clk) begin
    if (word_we) begin
      data_r[{word_index, word_offset}] <= word_data;
    end
    if (tag_we) begin
      tag_r[tag_index] <= tag_data;
    end
  end

  assign rd_tag  = tag_r[rd_index];
  assign rd_word = data_r[{rd_index, rd_offset}];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache answering fetch requests; misses refill
// the whole line from backing memory one word at a time, then respond once.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int                 INDEX_WIDTH = IC_INDEX_WIDTH,
  parameter int                 LINE_WORDS  = IC_LINE_WORDS,
  parameter logic [FAULT_W-1:0] STORE_FAULT = FAULT_STORE_ACCESS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  creq_valid,
  output logic                  creq_ready,
  input  logic [31:0]           creq_addr,
  input  logic                  creq_wen,
  input  logic [31:0]           creq_wdata,
  input  logic [MEM_SIZE_W-1:0] creq_wmask,
  output logic                  cresp_valid,
  output logic [31:0]           cresp_rdata,
  output logic                  cresp_error,
  output logic [FAULT_W-1:0]    cresp_errty,
  input  logic                  invalidate,
  output logic                  mreq_valid,
  input  logic                  mreq_ready,
  output logic [31:0]           mreq_addr,
  input  logic                  mresp_valid,
  input  logic [31:0]           mresp_rdata,
  input  logic                  mresp_error,
  input  logic [FAULT_W-1:0]    mresp_errty
);

  localparam int OW    = offset_width(LINE_WORDS);
  localparam int TW    = tag_width(INDEX_WIDTH, LINE_WORDS);
  localparam int LINES = 1 << INDEX_WIDTH;

  IcacheState           state_r;
  logic [TW-1:0]          req_tag_r;
  logic [INDEX_WIDTH-1:0] req_index_r;
  logic [OW-1:0]          req_offset_r;
  logic                   wen_r;
  logic                   hit_r;
  logic                   fault_r;
  FaultTy                 fault_ty_r;
  logic                   inv_pend_r;
  logic [OW-1:0]          cnt_r;
  logic [LINES-1:0]       valid_r;
  logic                   cresp_valid_r;
  logic [31:0]            cresp_rdata_r;
  logic                   cresp_error_r;
  FaultTy                 cresp_errty_r;
  logic                   mreq_valid_r;
  logic [31:0]            mreq_addr_r;

  logic [TW-1:0]          in_tag_s;
  logic [INDEX_WIDTH-1:0] in_index_s;
  logic [OW-1:0]          in_offset_s;
  logic [INDEX_WIDTH-1:0] rd_index_s;
  logic [OW-1:0]          rd_offset_s;
  logic [TW-1:0]          rd_tag_s;
  logic [31:0]            rd_word_s;
  logic                   accept_s;
  logic                   hit_s;
  logic                   last_word_s;
  logic [OW-1:0]          cnt_next_s;
  logic                   fault_now_s;
  FaultTy                 fault_ty_now_s;
  logic                   word_we_s;
  logic                   tag_we_s;
  logic                   refilling_s;
  logic                   unused_s;

  assign in_tag_s    = creq_addr[31 -: TW];
  assign in_index_s  = creq_addr[2 + OW +: INDEX_WIDTH];
  assign in_offset_s = creq_addr[2 +: OW];

  // Hit detection happens at accept, so the lookup port follows the bus while idle
  assign rd_index_s  = (state_r == IDLE) ? in_index_s  : req_index_r;
  assign rd_offset_s = (state_r == IDLE) ? in_offset_s : req_offset_r;

  assign creq_ready     = (state_r == IDLE) && !invalidate;
  assign accept_s       = creq_valid && creq_ready;
  assign hit_s          = valid_r[in_index_s] && (rd_tag_s == in_tag_s);
  assign last_word_s    = (cnt_r == OW'(LINE_WORDS - 1));
  assign cnt_next_s     = cnt_r + OW'(1'b1);
  assign fault_now_s    = fault_r || mresp_error;
  assign fault_ty_now_s = fault_r ? fault_ty_r : mresp_errty;
  assign word_we_s      = (state_r == REFILL_WAIT) && mresp_valid;
  assign tag_we_s       = (state_r == RESPOND) && !wen_r && !fault_r;
  assign refilling_s    = (state_r == REFILL_REQ) || (state_r == REFILL_WAIT) ||
                          (state_r == RESPOND);
  assign unused_s       = ^{creq_addr[1:0], creq_wdata, creq_wmask};

  icache_tag_ram #(
    .INDEX_WIDTH  (INDEX_WIDTH),
    .OFFSET_WIDTH (OW),
    .TAG_WIDTH    (TW)
  ) u_tag_ram (
    .clk         (clk),
    .word_we     (word_we_s),
    .word_index  (req_index_r),
    .word_offset (cnt_r),
    .word_data   (mresp_rdata),
    .tag_we      (tag_we_s),
    .tag_index   (req_index_r),
    .tag_data    (req_tag_r),
    .rd_index    (rd_index_s),
    .rd_offset   (rd_offset_s),
    .rd_tag      (rd_tag_s),
    .rd_word     (rd_word_s)
  );

  // Valid bits: invalidate wins over any per-line update in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= {LINES{1'b0}};
    end else if (invalidate) begin
      valid_r <= {LINES{1'b0}};
    end else if ((state_r == LOOKUP) && !wen_r && !hit_r) begin
      valid_r[req_index_r] <= 1'b0;
    end else if ((state_r == RESPOND) && !wen_r && !fault_r && !inv_pend_r) begin
      valid_r[req_index_r] <= 1'b1;
    end
  end

  // Request sequencing; every response and memory-request output is registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      req_tag_r     <= {TW{1'b0}};
      req_index_r   <= {INDEX_WIDTH{1'b0}};
      req_offset_r  <= {OW{1'b0}};
      wen_r         <= 1'b0;
      hit_r         <= 1'b0;
      fault_r       <= 1'b0;
      fault_ty_r    <= FAULT_NONE;
      inv_pend_r    <= 1'b0;
      cnt_r         <= {OW{1'b0}};
      cresp_valid_r <= 1'b0;
      cresp_rdata_r <= 32'd0;
      cresp_error_r <= 1'b0;
      cresp_errty_r <= FAULT_NONE;
      mreq_valid_r  <= 1'b0;
      mreq_addr_r   <= 32'd0;
    end else begin
      cresp_valid_r <= 1'b0;
      cresp_rdata_r <= 32'd0;
      cresp_error_r <= 1'b0;
      cresp_errty_r <= FAULT_NONE;
      if (invalidate && refilling_s) begin
        inv_pend_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            req_tag_r     <= in_tag_s;
            req_index_r   <= in_index_s;
            req_offset_r  <= in_offset_s;
            wen_r         <= creq_wen;
            hit_r         <= hit_s;
            cresp_valid_r <= hit_s && !creq_wen;
            cresp_rdata_r <= (hit_s && !creq_wen) ? rd_word_s : 32'd0;
            state_r       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (wen_r) begin
            cresp_valid_r <= 1'b1;
            cresp_error_r <= 1'b1;
            cresp_errty_r <= STORE_FAULT;
            state_r       <= RESPOND;
          end else if (hit_r) begin
            state_r <= IDLE;
          end else begin
            cnt_r        <= {OW{1'b0}};
            mreq_valid_r <= 1'b1;
            mreq_addr_r  <= {req_tag_r, req_index_r, {OW{1'b0}}, 2'b00};
            state_r      <= REFILL_REQ;
          end
        end
        REFILL_REQ: begin
          if (mreq_ready) begin
            mreq_valid_r <= 1'b0;
            state_r      <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (mresp_valid) begin
            if (mresp_error && !fault_r) begin
              fault_r    <= 1'b1;
              fault_ty_r <= mresp_errty;
            end
            if (last_word_s) begin
              // The requested word may be the one arriving now, so bypass the array
              cresp_valid_r <= 1'b1;
              cresp_error_r <= fault_now_s;
              cresp_errty_r <= fault_now_s ? fault_ty_now_s : FAULT_NONE;
              cresp_rdata_r <= fault_now_s ? 32'd0 :
                               ((req_offset_r == cnt_r) ? mresp_rdata : rd_word_s);
              state_r       <= RESPOND;
            end else begin
              cnt_r        <= cnt_next_s;
              mreq_valid_r <= 1'b1;
              mreq_addr_r  <= {req_tag_r, req_index_r, cnt_next_s, 2'b00};
              state_r      <= REFILL_REQ;
            end
          end
        end
        RESPOND: begin
          fault_r    <= 1'b0;
          fault_ty_r <= FAULT_NONE;
          inv_pend_r <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign cresp_valid = cresp_valid_r;
  assign cresp_rdata = cresp_rdata_r;
  assign cresp_error = cresp_error_r;
  assign cresp_errty = cresp_errty_r;
  assign mreq_valid  = mreq_valid_r;
  assign mreq_addr   = mreq_addr_r;

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: directed scenarios then randomized traffic
// against a line-level cache model and a word-addressed backing memory.
module tb_icache_responder;
  import icache_responder_pkg::*;

  localparam int          LINES      = 64;
  localparam int          LINE_BYTES = 16;
  localparam int          LWORDS     = 4;
  localparam logic [31:0] NO_FAULT   = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] rdata;
    logic        error;
    FaultTy      errty;
    int          kind;   // 0 hit, 1 miss, 2 store
  } sb_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  creq_valid = 1'b0;
  logic                  creq_ready;
  logic [31:0]           creq_addr = 32'd0;
  logic                  creq_wen = 1'b0;
  logic [31:0]           creq_wdata = 32'd0;
  logic [MEM_SIZE_W-1:0] creq_wmask = 2'd0;
  logic                  cresp_valid;
  logic [31:0]           cresp_rdata;
  logic                  cresp_error;
  FaultTy                cresp_errty;
  logic                  invalidate = 1'b0;
  logic                  mreq_valid;
  logic                  mreq_ready = 1'b0;
  logic [31:0]           mreq_addr;
  logic                  mresp_valid = 1'b0;
  logic [31:0]           mresp_rdata = 32'd0;
  logic                  mresp_error = 1'b0;
  FaultTy                mresp_errty = 4'd0;

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          pulse_cnt = 0;
  int          mem_lat = 2;
  int          rdy_max = 0;
  logic [31:0] fault_addr = NO_FAULT;
  FaultTy      fault_ty = 4'd0;

  sb_t         sb[$];
  logic [31:0] exp_mreq[$];
  bit          mv[LINES];
  logic [21:0] mt[LINES];

  icache_responder dut (
    .clk(clk), .reset(reset),
    .creq_valid(creq_valid), .creq_ready(creq_ready), .creq_addr(creq_addr),
    .creq_wen(creq_wen), .creq_wdata(creq_wdata), .creq_wmask(creq_wmask),
    .cresp_valid(cresp_valid), .cresp_rdata(cresp_rdata),
    .cresp_error(cresp_error), .cresp_errty(cresp_errty),
    .invalidate(invalidate),
    .mreq_valid(mreq_valid), .mreq_ready(mreq_ready), .mreq_addr(mreq_addr),
    .mresp_valid(mresp_valid), .mresp_rdata(mresp_rdata),
    .mresp_error(mresp_error), .mresp_errty(mresp_errty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1
  task automatic check_reset_state();
    @(negedge clk);
    chk("reset_cresp_valid", {31'd0, cresp_valid}, 32'd0);
    chk("reset_cresp_error", {31'd0, cresp_error}, 32'd0);
    chk("reset_mreq_valid", {31'd0, mreq_valid}, 32'd0);
    chk("reset_creq_ready", {31'd0, creq_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_inv();
    invalidate = 1'b1;
    @(posedge clk); #1;
    invalidate = 1'b0;
    model_clear();
  endtask

  // Issue one request; inv_delay>=0 pulses invalidate, kill_delay>=0 resets mid-flight
  task automatic do_req(input logic [31:0] a, input logic w, input int inv_delay,
                        input int kill_delay);
    sb_t         e;
    logic [31:0] wa;
    logic [31:0] base;
    int          idx;
    logic [21:0] tg;
    bit          flt;
    bit          acc;
    bit          r;
    wa   = {a[31:2], 2'b00};
    base = (wa / LINE_BYTES) * LINE_BYTES;
    idx  = int'((a / LINE_BYTES) % LINES);
    tg   = a[31:10];
    e.rdata = 32'd0; e.error = 1'b0; e.errty = 4'd0; e.kind = 0;
    if (w) begin
      e.kind = 2; e.error = 1'b1; e.errty = FAULT_STORE_ACCESS;
    end else if (mv[idx] && mt[idx] == tg) begin
      e.kind = 0; e.rdata = mem_word(wa);
    end else begin
      e.kind = 1;
      flt = 1'b0;
      for (int k = 0; k < LWORDS; k++) begin
        exp_mreq.push_back(base + 32'(4 * k));
        if (base + 32'(4 * k) == fault_addr) flt = 1'b1;
      end
      if (flt) begin
        e.error = 1'b1; e.errty = fault_ty; mv[idx] = 1'b0;
      end else begin
        e.rdata = mem_word(wa); mv[idx] = 1'b1; mt[idx] = tg;
      end
    end
    if (inv_delay >= 0) model_clear();
    sb.push_back(e);
    creq_addr = a; creq_wen = w; creq_wdata = $urandom; creq_wmask = 2'($urandom);
    creq_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk); r = creq_ready;
      @(posedge clk); #1;
      if (r) acc = 1'b1;
    end
    creq_valid = 1'b0;
    acc_cyc = cyc;
    n_checks++;
    if (!acc) begin
      n_err++;
      $display("FAIL accept_timeout: addr %h not accepted within 50 cycles", a);
      sb.delete(); exp_mreq.delete();
      return;
    end
    if (kill_delay >= 0) begin
      repeat (kill_delay) begin @(posedge clk); #1; end
      reset = 1'b1;
      sb.delete(); exp_mreq.delete(); model_clear();
      repeat (4) begin @(posedge clk); #1; end
      reset = 1'b0;
      return;
    end
    if (inv_delay >= 0) begin
      repeat (inv_delay) begin @(posedge clk); #1; end
      invalidate = 1'b1;
      @(posedge clk); #1;
      invalidate = 1'b0;
    end
    for (int t = 0; t < 300 && sb.size() > 0; t++) begin
      @(posedge clk); #1;
    end
    if (sb.size() > 0) begin
      n_checks++; n_err++;
      $display("FAIL resp_timeout: no response for addr %h", a);
      sb.delete(); exp_mreq.delete();
    end
  endtask

  // Backing memory: checks refill addresses and answers after a random delay
  initial begin
    logic [31:0] a;
    logic [31:0] ea;
    bit          er;
    forever begin
      @(negedge clk);
      if (!reset && mreq_valid) begin
        a = mreq_addr;
        n_checks++;
        if (exp_mreq.size() == 0) begin
          n_err++;
          $display("FAIL mreq_unexpected: got addr %h expected no request", a);
        end else begin
          ea = exp_mreq.pop_front();
          if (a !== ea) begin
            n_err++;
            $display("FAIL mreq_addr: got %h expected %h", a, ea);
          end
        end
        repeat ($urandom_range(0, rdy_max)) @(negedge clk);
        mreq_ready = 1'b1;
        @(posedge clk); #1;
        mreq_ready = 1'b0;
        repeat (mem_lat) begin @(posedge clk); #1; end
        er          = (a == fault_addr);
        mresp_valid = 1'b1;
        mresp_error = er;
        mresp_errty = er ? fault_ty : 4'd0;
        mresp_rdata = er ? $urandom : mem_word(a);
        @(posedge clk); #1;
        mresp_valid = 1'b0; mresp_error = 1'b0; mresp_errty = 4'd0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every cresp pulse
  initial begin
    sb_t e;
    bit  prev_valid;
    bit  bad;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && cresp_valid) begin
        pulse_cnt++;
        n_checks++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL cresp_unexpected: got pulse rdata=%h err=%b expected none",
                   cresp_rdata, cresp_error);
        end else begin
          e   = sb.pop_front();
          bad = (cresp_rdata !== e.rdata) || (cresp_error !== e.error) ||
                (e.error && (cresp_errty !== e.errty)) || prev_valid;
          if (bad) begin
            n_err++;
            $display("FAIL cresp_data: got rdata=%h err=%b ty=%h expected rdata=%h err=%b ty=%h",
                     cresp_rdata, cresp_error, cresp_errty, e.rdata, e.error, e.errty);
          end
          n_checks++;
          if (e.kind == 0) bad = (cyc != acc_cyc);
          else if (e.kind == 2) bad = (cyc != acc_cyc + 1) || (exp_mreq.size() != 0);
          else bad = (cyc - acc_cyc < 1 + 2 * LWORDS) || (exp_mreq.size() != 0);
          if (bad) begin
            n_err++;
            $display("FAIL cresp_timing: kind %0d got latency %0d with %0d refills left",
                     e.kind, cyc - acc_cyc, exp_mreq.size());
          end
        end
      end
      prev_valid = !reset && cresp_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          p0;
    int          inv;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state();

    mem_lat = 2; rdy_max = 0;
    do_req(32'h0000_0104, 1'b0, -1, -1);   // cold miss
    do_req(32'h0000_010C, 1'b0, -1, -1);   // hit after fill
    do_req(32'h0000_0500, 1'b0, -1, -1);   // conflict eviction
    do_req(32'h0000_0100, 1'b0, -1, -1);
    fault_addr = 32'h0000_0208; fault_ty = FAULT_LOAD_ACCESS;
    do_req(32'h0000_0200, 1'b0, -1, -1);   // refill fault
    fault_addr = NO_FAULT;
    do_req(32'h0000_0200, 1'b0, -1, -1);
    do_req(32'h0000_0040, 1'b1, -1, -1);   // store rejected
    do_req(32'h0000_0040, 1'b0, -1, -1);
    do_req(32'h0000_0300, 1'b0, 3, -1);    // invalidate during refill
    do_req(32'h0000_0304, 1'b0, -1, -1);
    pulse_inv();
    do_req(32'h0000_0300, 1'b0, -1, 4);    // reset mid-refill
    p0 = pulse_cnt;
    repeat (30) begin @(posedge clk); #1; end
    chk("no_pulse_after_reset", 32'(pulse_cnt), 32'(p0));
    check_reset_state();
    do_req(32'h0000_0300, 1'b0, -1, -1);

    rdy_max = 2;
    for (int i = 0; i < 150; i++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      mem_lat = $urandom_range(0, 3);
      fault_ty = FaultTy'($urandom_range(1, 15));
      fault_addr = ($urandom_range(0, 9) == 0) ?
                   ((a / LINE_BYTES) * LINE_BYTES + 32'(4 * $urandom_range(0, 3))) : NO_FAULT;
      inv = ($urandom_range(0, 14) == 0) ? $urandom_range(2, 4) : -1;
      do_req(a, ($urandom_range(0, 9) == 0), inv, -1);
      fault_addr = NO_FAULT;
    end
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
